// File: rtl/mmio_arbiter_if.sv
// Requester and device signal bundle for the shared MMIO peripheral bus.
// The arbiter takes the slave view; the requesters/devices side takes the master view.
interface mmio_arbiter_if;
    logic [1:0]        IN_req;
    logic [1:0]        IN_we;
    logic [1:0][29:0]  IN_addr;
    logic [1:0][3:0]   IN_wmask;
    logic [1:0][31:0]  IN_wdata;
    logic [1:0]        OUT_gnt;
    logic [1:0]        OUT_rvalid;
    logic [1:0]        OUT_rerr;
    logic [31:0]       OUT_rdata;
    logic [1:0]        OUT_devRe;
    logic [1:0]        OUT_devWe;
    logic [29:0]       OUT_devAddr;
    logic [3:0]        OUT_devWmask;
    logic [31:0]       OUT_devWdata;
    logic [1:0]        IN_devRbusy;
    logic [1:0]        IN_devRvalid;
    logic [1:0][31:0]  IN_devRdata;

    modport slave (
        input  IN_req, IN_we, IN_addr, IN_wmask, IN_wdata,
        input  IN_devRbusy, IN_devRvalid, IN_devRdata,
        output OUT_gnt, OUT_rvalid, OUT_rerr, OUT_rdata,
        output OUT_devRe, OUT_devWe, OUT_devAddr, OUT_devWmask, OUT_devWdata
    );

    modport master (
        output IN_req, IN_we, IN_addr, IN_wmask, IN_wdata,
        output IN_devRbusy, IN_devRvalid, IN_devRdata,
        input  OUT_gnt, OUT_rvalid, OUT_rerr, OUT_rdata,
        input  OUT_devRe, OUT_devWe, OUT_devAddr, OUT_devWmask, OUT_devWdata
    );
endinterface

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing the timer and syscon
// register ports; single-word transfers with read-response timeout.
module mmio_arbiter #(
    parameter logic [31:0] DEV0_BASE = 32'h0200_0000,
    parameter logic [31:0] DEV0_MASK = 32'hFFFF_0000,
    parameter logic [31:0] DEV1_BASE = 32'hFF00_0000,
    parameter logic [31:0] DEV1_MASK = 32'hFFFF_FFF0,
    parameter int          TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst,
    mmio_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_ptr;
    logic        r_id;
    logic        r_we;
    logic        r_map;
    logic        r_dev;
    logic [7:0]  r_cnt;
    logic [1:0]  r_gnt;
    logic [1:0]  r_rvalid;
    logic [1:0]  r_rerr;
    logic [31:0] r_rdata;
    logic [1:0]  r_devRe;
    logic [1:0]  r_devWe;
    logic [29:0] r_devAddr;
    logic [3:0]  r_devWmask;
    logic [31:0] r_devWdata;

    logic [1:0]  w_hit0;
    logic [1:0]  w_hit1;
    logic [1:0]  w_map;
    logic [1:0]  w_elig;
    logic        w_win;
    logic        w_tdev;

    // Device 0 takes priority on overlapping decode; unmapped targets never stall.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_hit0[i] = (({bus.IN_addr[i], 2'b00} & DEV0_MASK) == DEV0_BASE);
            w_hit1[i] = (({bus.IN_addr[i], 2'b00} & DEV1_MASK) == DEV1_BASE);
            w_map[i]  = w_hit0[i] | w_hit1[i];
            w_elig[i] = bus.IN_req[i] &
                        (~w_map[i] | ~(w_hit0[i] ? bus.IN_devRbusy[0] : bus.IN_devRbusy[1]));
        end
        w_win  = (&w_elig) ? r_ptr : w_elig[1];
        w_tdev = ~w_hit0[w_win];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= 1'b0;
            r_id       <= 1'b0;
            r_we       <= 1'b0;
            r_map      <= 1'b0;
            r_dev      <= 1'b0;
            r_cnt      <= 8'd0;
            r_gnt      <= 2'b00;
            r_rvalid   <= 2'b00;
            r_rerr     <= 2'b00;
            r_rdata    <= 32'd0;
            r_devRe    <= 2'b00;
            r_devWe    <= 2'b00;
            r_devAddr  <= 30'd0;
            r_devWmask <= 4'd0;
            r_devWdata <= 32'd0;
        end else begin
            r_gnt      <= 2'b00;
            r_rvalid   <= 2'b00;
            r_rerr     <= 2'b00;
            r_rdata    <= 32'd0;
            r_devRe    <= 2'b00;
            r_devWe    <= 2'b00;
            r_devAddr  <= 30'd0;
            r_devWmask <= 4'd0;
            r_devWdata <= 32'd0;
            case (r_state)
                S_IDLE: begin
                    if (|w_elig) begin
                        r_id         <= w_win;
                        r_we         <= bus.IN_we[w_win];
                        r_map        <= w_map[w_win];
                        r_dev        <= w_tdev;
                        r_ptr        <= ~w_win;
                        r_gnt[w_win] <= 1'b1;
                        if (w_map[w_win]) begin
                            if (bus.IN_we[w_win]) r_devWe[w_tdev] <= 1'b1;
                            else                  r_devRe[w_tdev] <= 1'b1;
                        end
                        r_devAddr  <= bus.IN_addr[w_win];
                        r_devWmask <= bus.IN_wmask[w_win];
                        r_devWdata <= bus.IN_wdata[w_win];
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        r_state <= S_IDLE;
                    end else if (r_map) begin
                        r_cnt   <= 8'd0;
                        r_state <= S_WAIT;
                    end else begin
                        r_rvalid[r_id] <= 1'b1;
                        r_rerr[r_id]   <= 1'b1;
                        r_state        <= S_RESP;
                    end
                end
                S_WAIT: begin
                    // Data arriving on the expiry cycle takes precedence over the error.
                    if (bus.IN_devRvalid[r_dev]) begin
                        r_rvalid[r_id] <= 1'b1;
                        r_rdata        <= bus.IN_devRdata[r_dev];
                        r_state        <= S_RESP;
                    end else if (r_cnt == TO_LAST) begin
                        r_rvalid[r_id] <= 1'b1;
                        r_rerr[r_id]   <= 1'b1;
                        r_state        <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.OUT_gnt      = r_gnt;
    assign bus.OUT_rvalid   = r_rvalid;
    assign bus.OUT_rerr     = r_rerr;
    assign bus.OUT_rdata    = r_rdata;
    assign bus.OUT_devRe    = r_devRe;
    assign bus.OUT_devWe    = r_devWe;
    assign bus.OUT_devAddr  = r_devAddr;
    assign bus.OUT_devWmask = r_devWmask;
    assign bus.OUT_devWdata = r_devWdata;
endmodule

// File: tb/tb_mmio_arbiter.sv
// Scoreboard bench for mmio_arbiter: expectations queued at issue time, popped by a monitor.
module tb_mmio_arbiter;
    localparam int T = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_arbiter_if bus();
    mmio_arbiter #(.TIMEOUT(T)) dut (.clk(clk), .rst(rst), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic ref_ptr = 1'b0;

    typedef struct packed { logic id; logic [31:0] cy; } gnt_t;
    typedef struct packed {
        logic [1:0] re; logic [1:0] we; logic [29:0] addr;
        logic [3:0] wm; logic [31:0] wd; logic [31:0] cy;
    } strb_t;
    typedef struct packed { logic id; logic err; logic [31:0] data; logic [31:0] cy; } resp_t;

    gnt_t  gnt_q[$];
    strb_t strb_q[$];
    resp_t resp_q[$];

    logic [31:0] mem0[logic [29:0]];
    logic [31:0] mem1[logic [29:0]];
    logic [31:0] ref0[logic [29:0]];
    logic [31:0] ref1[logic [29:0]];
    int          lat_cfg[2];
    logic [1:0]  pend;
    int          pend_cyc[2];
    logic [31:0] pend_data[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_val(input int d, input logic [29:0] a);
        return {a, 2'b00} ^ ((d == 1) ? 32'hA5A5_0000 : 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [3:0] m, input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = m[b] ? w[b*8 +: 8] : o[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] dev_get(input int d, input logic [29:0] a);
        if (d == 0) return mem0.exists(a) ? mem0[a] : init_val(0, a);
        return mem1.exists(a) ? mem1[a] : init_val(1, a);
    endfunction

    function automatic logic [31:0] ref_get(input int d, input logic [29:0] a);
        if (d == 0) return ref0.exists(a) ? ref0[a] : init_val(0, a);
        return ref1.exists(a) ? ref1[a] : init_val(1, a);
    endfunction

    // Address map as byte ranges.
    function automatic int ref_dev(input logic [31:0] b);
        if (b >= 32'h0200_0000 && b <= 32'h0200_FFFF) return 0;
        if (b >= 32'hFF00_0000 && b <= 32'hFF00_000F) return 1;
        return 2;
    endfunction

    // Device models: latency lat_cfg cycles after the read strobe, 0 = never answers.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (pend[d] && cyc == pend_cyc[d]) begin
                bus.IN_devRvalid[d] = 1'b1;
                bus.IN_devRdata[d]  = pend_data[d];
                pend[d] = 1'b0;
            end else begin
                bus.IN_devRvalid[d] = 1'b0;
                bus.IN_devRdata[d]  = $urandom;
            end
            if (bus.OUT_devWe[d]) begin
                if (d == 0) mem0[bus.OUT_devAddr] = merge(dev_get(0, bus.OUT_devAddr), bus.OUT_devWmask, bus.OUT_devWdata);
                else        mem1[bus.OUT_devAddr] = merge(dev_get(1, bus.OUT_devAddr), bus.OUT_devWmask, bus.OUT_devWdata);
            end
            if (bus.OUT_devRe[d] && lat_cfg[d] > 0) begin
                pend[d]      = 1'b1;
                pend_cyc[d]  = cyc + lat_cfg[d];
                pend_data[d] = dev_get(d, bus.OUT_devAddr);
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (|bus.OUT_gnt) begin
                if (gnt_q.size() == 0) chk("gnt_unexpected", 64'(bus.OUT_gnt), 64'd0);
                else begin
                    gnt_t e;
                    e = gnt_q.pop_front();
                    chk("gnt_id", 64'(bus.OUT_gnt), e.id ? 64'd2 : 64'd1);
                    chk("gnt_cycle", 64'(cyc), 64'(e.cy));
                end
            end else begin
                chk("quiet_addr", 64'(bus.OUT_devAddr), 64'd0);
                chk("quiet_wbus", 64'({bus.OUT_devWmask, bus.OUT_devWdata}), 64'd0);
            end
            if (|{bus.OUT_devRe, bus.OUT_devWe}) begin
                if (strb_q.size() == 0) chk("strobe_unexpected", 64'({bus.OUT_devRe, bus.OUT_devWe}), 64'd0);
                else begin
                    strb_t s;
                    s = strb_q.pop_front();
                    chk("strobe_re_we", 64'({bus.OUT_devRe, bus.OUT_devWe}), 64'({s.re, s.we}));
                    chk("strobe_addr", 64'(bus.OUT_devAddr), 64'(s.addr));
                    chk("strobe_wmask", 64'(bus.OUT_devWmask), 64'(s.wm));
                    chk("strobe_wdata", 64'(bus.OUT_devWdata), 64'(s.wd));
                    chk("strobe_cycle", 64'(cyc), 64'(s.cy));
                end
            end
            if (|bus.OUT_rvalid) begin
                if (resp_q.size() == 0) chk("rvalid_unexpected", 64'(bus.OUT_rvalid), 64'd0);
                else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    chk("rvalid_id", 64'(bus.OUT_rvalid), r.id ? 64'd2 : 64'd1);
                    chk("rerr", 64'(bus.OUT_rerr), r.err ? (r.id ? 64'd2 : 64'd1) : 64'd0);
                    chk("rdata", 64'(bus.OUT_rdata), 64'(r.data));
                    chk("rvalid_cycle", 64'(cyc), 64'(r.cy));
                end
            end else begin
                chk("quiet_resp", 64'({bus.OUT_rerr, bus.OUT_rdata}), 64'd0);
            end
        end
    end

    // Queue what one granted request should produce; g is its grant cycle.
    // Returns the first cycle the arbiter is free again.
    function automatic int expect_one(input int r, input logic we, input logic [31:0] b,
                                      input logic [3:0] wm, input logic [31:0] wd,
                                      input int g, input int lat);
        int d;
        gnt_t ge; strb_t se; resp_t re;
        d = ref_dev(b);
        ge.id = r[0]; ge.cy = g; gnt_q.push_back(ge);
        ref_ptr = ~r[0];
        if (d < 2) begin
            se.re = (!we) ? 2'(1 << d) : 2'b00;
            se.we = we ? 2'(1 << d) : 2'b00;
            se.addr = b[31:2]; se.wm = wm; se.wd = wd; se.cy = g;
            strb_q.push_back(se);
        end
        if (we) begin
            if (d == 0) ref0[b[31:2]] = merge(ref_get(0, b[31:2]), wm, wd);
            if (d == 1) ref1[b[31:2]] = merge(ref_get(1, b[31:2]), wm, wd);
            return g + 1;
        end
        re.id = r[0];
        if (d == 2) begin
            re.err = 1'b1; re.data = 32'd0; re.cy = g + 1;
        end else if (lat > 0 && lat <= T) begin
            re.err = 1'b0; re.data = ref_get(d, b[31:2]); re.cy = g + 1 + lat;
        end else begin
            re.err = 1'b1; re.data = 32'd0; re.cy = g + 1 + T;
        end
        resp_q.push_back(re);
        return re.cy + 1;
    endfunction

    task automatic drive(input int r, input logic we, input logic [31:0] b,
                         input logic [3:0] wm, input logic [31:0] wd);
        logic ok;
        ok = 1'b0;
        bus.IN_we[r] = we; bus.IN_addr[r] = b[31:2];
        bus.IN_wmask[r] = wm; bus.IN_wdata[r] = wd;
        bus.IN_req[r] = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (bus.OUT_gnt[r]) ok = 1'b1;
        end
        bus.IN_req[r] = 1'b0;
        chk($sformatf("grant_wait_r%0d", r), 64'(ok), 64'd1);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic txn(input int r, input logic we, input logic [31:0] b,
                       input logic [3:0] wm, input logic [31:0] wd, input int lat);
        int d, c, done;
        d = ref_dev(b);
        c = cyc;
        if (d < 2) lat_cfg[d] = lat;
        done = expect_one(r, we, b, wm, wd, c + 1, lat);
        drive(r, we, b, wm, wd);
        wait_until(done);
    endtask

    task automatic pair_wr(input logic [31:0] b0, input logic [3:0] m0, input logic [31:0] d0,
                           input logic [31:0] b1, input logic [3:0] m1, input logic [31:0] d1);
        int c, w, dn;
        c = cyc;
        w = int'(ref_ptr);
        if (w == 0) begin
            dn = expect_one(0, 1'b1, b0, m0, d0, c + 1, 0);
            dn = expect_one(1, 1'b1, b1, m1, d1, c + 3, 0);
        end else begin
            dn = expect_one(1, 1'b1, b1, m1, d1, c + 1, 0);
            dn = expect_one(0, 1'b1, b0, m0, d0, c + 3, 0);
        end
        fork
            drive(0, 1'b1, b0, m0, d0);
            drive(1, 1'b1, b1, m1, d1);
        join
        wait_until(dn);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] edges [6];
        edges[0] = 32'h0201_0000; edges[1] = 32'hFF00_0010; edges[2] = 32'h01FF_FFFC;
        edges[3] = 32'hFEFF_FFFC; edges[4] = 32'h0200_FFFC; edges[5] = 32'hFF00_000C;
        case ($urandom_range(0, 4))
            0, 4:    return 32'h0200_0000 | ($urandom & 32'h0000_FFFC);
            1:       return 32'hFF00_0000 | ($urandom & 32'h0000_000C);
            2:       return $urandom & 32'hFFFF_FFFC;
            default: return edges[$urandom_range(0, 5)];
        endcase
    endfunction

    logic [63:0] all_out;
    assign all_out = {bus.OUT_gnt, bus.OUT_rvalid, bus.OUT_rerr, bus.OUT_devRe, bus.OUT_devWe,
                      bus.OUT_devWmask, |bus.OUT_rdata, |bus.OUT_devAddr, |bus.OUT_devWdata};

    initial begin
        int c, dn;
        bus.IN_req = '0; bus.IN_we = '0; bus.IN_addr = '0; bus.IN_wmask = '0; bus.IN_wdata = '0;
        bus.IN_devRbusy = '0; bus.IN_devRvalid = '0; bus.IN_devRdata = '0;
        lat_cfg[0] = 1; lat_cfg[1] = 1; pend = '0; pend_cyc[0] = 0; pend_cyc[1] = 0;
        pend_data[0] = 0; pend_data[1] = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_out, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous writes straight out of reset: requester 0 first.
        pair_wr(32'h0200_0010, 4'b0011, 32'h1111_2222, 32'hFF00_0004, 4'b1100, 32'h3333_4444);
        txn(0, 1'b0, 32'h0200_0010, 4'h0, 32'h0, 1);
        txn(1, 1'b0, 32'hFF00_0004, 4'h0, 32'h0, 2);

        // One-cycle device read.
        mem0[30'h0080_0000] = 32'hDEAD_BEEF; ref0[30'h0080_0000] = 32'hDEAD_BEEF;
        txn(0, 1'b0, 32'h0200_0000, 4'hF, 32'h0, 1);

        // Unmapped read and write.
        txn(1, 1'b0, 32'h1000_0000, 4'hF, 32'h0, 1);
        txn(1, 1'b1, 32'h1000_0000, 4'hF, 32'hCAFE_F00D, 1);

        // Timeout, data on the expiry cycle, data one cycle too late.
        txn(0, 1'b0, 32'hFF00_0008, 4'h0, 32'h0, 0);
        txn(0, 1'b0, 32'hFF00_0008, 4'h0, 32'h0, T);
        txn(0, 1'b0, 32'hFF00_0008, 4'h0, 32'h0, T + 1);
        repeat (2) @(negedge clk);

        // Busy device 0 must not block requester 1.
        c = cyc;
        bus.IN_devRbusy = 2'b01;
        dn = expect_one(1, 1'b1, 32'hFF00_0000, 4'hF, 32'h0BB0_0001, c + 1, 0);
        dn = expect_one(0, 1'b1, 32'h0200_0100, 4'hF, 32'h0AA0_0001, c + 5, 0);
        fork
            drive(0, 1'b1, 32'h0200_0100, 4'hF, 32'h0AA0_0001);
            drive(1, 1'b1, 32'hFF00_0000, 4'hF, 32'h0BB0_0001);
            begin wait_until(c + 4); bus.IN_devRbusy = 2'b00; end
        join
        wait_until(dn);

        // Reset while waiting for a slow device; its late response must be dropped.
        c = cyc;
        lat_cfg[0] = 6;
        dn = expect_one(0, 1'b0, 32'h0200_0100, 4'h0, 32'h0, c + 1, 6);
        void'(resp_q.pop_back());
        drive(0, 1'b0, 32'h0200_0100, 4'h0, 32'h0);
        wait_until(c + 3);
        #1 rst = 1'b1;
        #1 chk("reset_in_wait", all_out, 64'd0);
        wait_until(c + 5);
        rst = 1'b0; ref_ptr = 1'b0;
        wait_until(c + 10);
        txn(0, 1'b0, 32'h0200_0100, 4'h0, 32'h0, 1);

        // Reset in the grant cycle clears outputs without waiting for a clock edge.
        c = cyc;
        lat_cfg[1] = 2;
        dn = expect_one(1, 1'b0, 32'hFF00_0000, 4'h0, 32'h0, c + 1, 2);
        void'(resp_q.pop_back());
        drive(1, 1'b0, 32'hFF00_0000, 4'h0, 32'h0);
        #1 rst = 1'b1;
        #1 chk("reset_async", all_out, 64'd0);
        wait_until(c + 3);
        rst = 1'b0; ref_ptr = 1'b0;
        wait_until(c + 6);
        txn(1, 1'b0, 32'hFF00_0000, 4'h0, 32'h0, 1);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 3)
                pair_wr(rand_addr(), 4'($urandom), $urandom, rand_addr(), 4'($urandom), $urandom);
            else
                txn($urandom_range(0, 1), 1'($urandom), rand_addr(), 4'($urandom), $urandom,
                    $urandom_range(0, 10));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (12) @(negedge clk);
        chk("gnt_queue_empty", 64'(gnt_q.size()), 64'd0);
        chk("strobe_queue_empty", 64'(strb_q.size()), 64'd0);
        chk("resp_queue_empty", 64'(resp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
